// File: rtl/rv32i_multicycle_core.sv
// Multicycle RV32I core: one instruction at a time through FETCH/DECODE/EXECUTE/MEM states.
// Latency (zero-wait memory): ALU/jump/branch 4 cycles, store 5, load 6; one extra idle cycle after reset.
// Backpressure: holds in WAIT_INSTR/WAIT_DATA while mem_rbusy, in WAIT_STORE while mem_wbusy.
// Ports: clk/rst_n (async active-low); mem_addr/mem_rstrb/mem_rdata/mem_rbusy read channel;
//        mem_wdata/mem_wmask/mem_wbusy write channel; x1 mirrors register x1; halted after SYSTEM.
module rv32i_multicycle_core #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 24,
  parameter int          NREGS      = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        mem_rstrb,
  input  logic        mem_rbusy,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_wbusy,
  output logic [31:0] x1,
  output logic        halted
);
  localparam int          RW        = $clog2(NREGS);
  localparam logic [5:0]  NREGS_L   = 6'(NREGS);
  localparam logic [31:0] ADDR_MASK = (ADDR_WIDTH >= 32) ? 32'hFFFF_FFFF
                                                         : ((32'd1 << ADDR_WIDTH) - 32'd1);

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011,
                         OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FETCH_INSTR, WAIT_INSTR, FETCH_REGS, EXECUTE, LOAD, WAIT_DATA, WAIT_STORE, HALT
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q, instr_q, rs1_q, rs2_q, addr_q, wdata_q;
  logic        rstrb_q, halted_q;
  logic [3:0]  wmask_q;
  logic [31:0] rf_q [NREGS];

  // x0 and unimplemented indices read as zero
  function automatic logic [31:0] rf_rd(input logic [4:0] idx);
    logic [31:0] v;
    v = 32'd0;
    if (idx != 5'd0 && {1'b0, idx} < NREGS_L) v = rf_q[idx[RW-1:0]];
    return v;
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, pc_plus4;
  assign opcode   = instr_q[6:0];
  assign funct3   = instr_q[14:12];
  assign rd       = instr_q[11:7];
  assign imm_i    = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s    = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b    = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u    = {instr_q[31:12], 12'b0};
  assign imm_j    = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
  assign pc_plus4 = pc_q + 32'd4;

  // ALU: second operand is rs2 for register ops, the I-immediate otherwise
  logic [31:0] alu_b, alu_res;
  logic [4:0]  shamt;
  always_comb begin
    alu_b = (opcode == OP_REG) ? rs2_q : imm_i;
    shamt = alu_b[4:0];
    case (funct3)
      3'b000:  alu_res = (opcode == OP_REG && instr_q[30]) ? rs1_q - alu_b : rs1_q + alu_b;
      3'b001:  alu_res = rs1_q << shamt;
      3'b010:  alu_res = {31'b0, $signed(rs1_q) < $signed(alu_b)};
      3'b011:  alu_res = {31'b0, rs1_q < alu_b};
      3'b100:  alu_res = rs1_q ^ alu_b;
      3'b101:  alu_res = instr_q[30] ? 32'($signed(rs1_q) >>> shamt) : rs1_q >> shamt;
      3'b110:  alu_res = rs1_q | alu_b;
      default: alu_res = rs1_q & alu_b;
    endcase
  end

  logic        br_taken;
  logic [31:0] pc_next;
  always_comb begin
    case (funct3)
      3'b000:  br_taken = (rs1_q == rs2_q);
      3'b001:  br_taken = (rs1_q != rs2_q);
      3'b100:  br_taken = ($signed(rs1_q) < $signed(rs2_q));
      3'b101:  br_taken = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  br_taken = (rs1_q < rs2_q);
      3'b111:  br_taken = (rs1_q >= rs2_q);
      default: br_taken = 1'b0;
    endcase
    pc_next = pc_plus4;
    case (opcode)
      OP_JAL:    pc_next = pc_q + imm_j;
      OP_JALR:   pc_next = (rs1_q + imm_i) & 32'hFFFF_FFFE;
      OP_BRANCH: if (br_taken) pc_next = pc_q + imm_b;
      default:   ;
    endcase
  end

  // Load lane extraction; addr_q still holds the load address in WAIT_DATA
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_res;
  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_b = mem_rdata[7:0];
      2'd1:    ld_b = mem_rdata[15:8];
      2'd2:    ld_b = mem_rdata[23:16];
      default: ld_b = mem_rdata[31:24];
    endcase
    ld_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3)
      3'b000:  ld_res = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_res = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_res = {24'b0, ld_b};
      3'b101:  ld_res = {16'b0, ld_h};
      default: ld_res = mem_rdata;
    endcase
  end

  // Store lanes are formed from the register file directly in FETCH_REGS so the
  // write mask can be registered and present during EXECUTE.
  logic [31:0] st_rs1, st_rs2, st_addr, st_wdata;
  logic [3:0]  st_mask;
  always_comb begin
    st_rs1  = rf_rd(instr_q[19:15]);
    st_rs2  = rf_rd(instr_q[24:20]);
    st_addr = st_rs1 + imm_s;
    case (funct3[1:0])
      2'b00: begin st_mask = 4'b0001 << st_addr[1:0]; st_wdata = {4{st_rs2[7:0]}}; end
      2'b01: begin st_mask = st_addr[1] ? 4'b1100 : 4'b0011; st_wdata = {2{st_rs2[15:0]}}; end
      default: begin st_mask = 4'b1111; st_wdata = st_rs2; end
    endcase
  end

  logic        rf_we;
  logic [31:0] rf_wd;
  always_comb begin
    rf_we = 1'b0;
    rf_wd = 32'd0;
    if (state_q == EXECUTE) begin
      case (opcode)
        OP_LUI:          begin rf_we = 1'b1; rf_wd = imm_u;          end
        OP_AUIPC:        begin rf_we = 1'b1; rf_wd = pc_q + imm_u;   end
        OP_JAL, OP_JALR: begin rf_we = 1'b1; rf_wd = pc_plus4;       end
        OP_IMM, OP_REG:  begin rf_we = 1'b1; rf_wd = alu_res;        end
        default:         ;
      endcase
    end else if (state_q == WAIT_DATA && !mem_rbusy) begin
      rf_we = 1'b1;
      rf_wd = ld_res;
    end
    rf_we = rf_we && rst_n;
  end

  always_ff @(posedge clk) begin
    if (rf_we && rd != 5'd0 && {1'b0, rd} < NREGS_L) rf_q[rd[RW-1:0]] <= rf_wd;
  end

  // Strobe and mask are one-cycle pulses armed on entry to their state. Out of
  // reset the strobe is not yet armed, so FETCH_INSTR spends one cycle arming it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH_INSTR;
      pc_q     <= RESET_ADDR;
      addr_q   <= RESET_ADDR;
      instr_q  <= 32'd0;
      rs1_q    <= 32'd0;
      rs2_q    <= 32'd0;
      wdata_q  <= 32'd0;
      rstrb_q  <= 1'b0;
      wmask_q  <= 4'd0;
      halted_q <= 1'b0;
    end else begin
      rstrb_q <= 1'b0;
      wmask_q <= 4'd0;
      case (state_q)
        FETCH_INSTR: begin
          if (!rstrb_q) begin
            addr_q  <= pc_q;
            rstrb_q <= 1'b1;
          end else begin
            state_q <= WAIT_INSTR;
          end
        end
        WAIT_INSTR: if (!mem_rbusy) begin
          instr_q <= mem_rdata;
          state_q <= FETCH_REGS;
        end
        FETCH_REGS: begin
          rs1_q <= st_rs1;
          rs2_q <= st_rs2;
          if (opcode == OP_STORE) begin
            addr_q  <= st_addr;
            wdata_q <= st_wdata;
            wmask_q <= st_mask;
          end
          state_q <= EXECUTE;
        end
        EXECUTE: begin
          case (opcode)
            OP_LOAD: begin
              addr_q  <= rs1_q + imm_i;
              rstrb_q <= 1'b1;
              state_q <= LOAD;
            end
            OP_STORE:  state_q <= WAIT_STORE;
            OP_SYSTEM: begin
              halted_q <= 1'b1;
              state_q  <= HALT;
            end
            default: begin
              pc_q    <= pc_next;
              addr_q  <= pc_next;
              rstrb_q <= 1'b1;
              state_q <= FETCH_INSTR;
            end
          endcase
        end
        LOAD: state_q <= WAIT_DATA;
        WAIT_DATA, WAIT_STORE: begin
          if ((state_q == WAIT_DATA && !mem_rbusy) || (state_q == WAIT_STORE && !mem_wbusy)) begin
            pc_q    <= pc_plus4;
            addr_q  <= pc_plus4;
            rstrb_q <= 1'b1;
            state_q <= FETCH_INSTR;
          end
        end
        default: state_q <= HALT;
      endcase
    end
  end

  assign mem_addr  = addr_q & ADDR_MASK;
  assign mem_rstrb = rstrb_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign x1        = rf_q[1];
  assign halted    = halted_q;
endmodule
